fast_protocol_mul_arbiter: RTL
==============================

Name: fast_protocol_mul_arbiter

Overview:
- Round-robin arbiter and 2-stage pipeline that time-shares one signed-16 x unsigned-9 -> 16-bit multiplier among NUM_REQ FAST-decoder field units (price/qty scaling).
- Accepts at most one request per cycle and returns the tagged, truncated product with an overflow flag.
- Uses valid/ready handshakes on both sides, with full backpressure from the consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester tag width (>= clog2(NUM_REQ)).
- A_W, 16, signed multiplicand width.
- B_W, 9, unsigned multiplier width.
- P_W, 16, result width (low P_W bits of the product).

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*A_W  packed signed operands; requester i occupies bits [i*A_W +: A_W].
- req_b  in  NUM_REQ*B_W  packed unsigned operands; requester i occupies bits [i*B_W +: B_W].
- req_ready  out  NUM_REQ  one-hot grant-and-accept; a request transfers when req_valid[i] & req_ready[i].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer ready.
- rsp_id  out  ID_W  index of the requester that issued the result.
- rsp_data  out  P_W  low P_W bits of $signed(a) * $signed({1'b0, b}).
- rsp_ovf  out  1  set when the full A_W+B_W+1-bit product is outside the signed P_W range.
- busy  out  1  op_v | rsp_valid.

Behaviour:
- Reset (async assert, sync deassert):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0.
  - Operand stage op_v=0.
  - Round-robin pointer rr_ptr=0, so requester 0 has highest priority first.
- Advance: adv_rsp = !rsp_valid | rsp_ready; adv_op = !op_v | adv_rsp.
- Arbitration (combinational):
  - Search indices rr_ptr, rr_ptr+1, ... mod NUM_REQ; the first asserted req_valid wins.
  - req_ready[win] = adv_op; all other req_ready bits are 0.
  - req_ready never depends on rsp_ready except through adv_op.
- Accept: on a transfer, latch op_a, op_b and op_id=win, set op_v=1, and set rr_ptr=(win+1) mod NUM_REQ.
- No transfer: rr_ptr holds. op_v clears when it advances and there is no new accept.
- Stage 2:
  - When adv_rsp and op_v: compute full = signed(op_a) * signed({0,op_b}) at A_W+B_W+1 bits.
  - Register rsp_data=full[P_W-1:0], rsp_ovf=(full[A_W+B_W:P_W-1] not all equal), rsp_id=op_id, rsp_valid=1.
  - When adv_rsp and !op_v: rsp_valid=0; data and id hold their old values.
- Latency: exactly 2 cycles from the accept edge to rsp_valid, with no stalls. Sustained throughput is 1 result/cycle when rsp_ready=1.
- Stall: with rsp_valid=1 & rsp_ready=0, rsp_* hold stable.
  - If op_v=1, the operand stage also holds and req_ready is all 0.
  - If op_v=0, one more request may be accepted into the operand stage.
- Empty: no req_valid -> req_ready all 0 and no pointer change.
- Single requester: a continuously valid requester i is granted every cycle; the pointer wrapping past i is harmless.
- Ordering: results return in acceptance order; no reordering and no drops.
- Reset mid-operation: in-flight operand and result are discarded immediately, rsp_valid drops asynchronously, and the pointer returns to 0.
- b=0 -> rsp_data=0, rsp_ovf=0.
- Largest negative a with b=511 is a legal input (see test 3).

Test Plan:
1. Directed product values, requester 0 only:
   - a=-300, b=100 -> rsp_data=0x8AD0, ovf=0.
   - a=32767, b=1 -> 0x7FFF, ovf=0.
   - a=1000, b=100 -> 0x86A0, ovf=1.
   - Each result appears exactly 2 cycles after accept.
2. All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles; rsp_id follows the same sequence with a 2-cycle lag; one result per cycle.
3. a=-32768, b=511 on requester 2 -> rsp_data=0x8000, ovf=1, rsp_id=2.
4. Backpressure:
   - Accept on requesters 1 and 3, then rsp_ready=0 for 3 cycles -> rsp_* stable, req_ready all 0 while both stages are full.
   - rsp_ready=1 -> results for id 1 then id 3 are delivered without loss; busy falls after the last handshake.
5. Fairness: requesters 0 and 1 always valid, requester 3 asserts valid at cycle 5 -> requester 3 is granted within 3 grants of assertion; no requester is granted twice while another valid requester waits a full rotation.
6. Reset mid-stream:
   - Assert ap_rst while op_v=1 and rsp_valid=1 -> rsp_valid=0 immediately and busy=0.
   - After release, requesters 2 and 0 both valid -> requester 0 is granted first (pointer back at 0).

Source files
------------

// File: rtl/fast_protocol_mul_arbiter.sv
// ---------------------------------------------------------------------------
// fast_protocol_mul_arbiter
//
// Time-shares one signed A_W x unsigned B_W multiplier among NUM_REQ FAST
// field-decoder units (price / quantity scaling). A round-robin arbiter
// accepts at most one request per cycle into an operand register. The
// following stage multiplies, truncates to P_W bits and flags overflow.
// Both sides use valid/ready handshakes, and consumer backpressure propagates
// all the way to the requesters.
//
// Ports
//   ap_clk     clock
//   ap_rst     asynchronous, active-high reset
//   req_valid  per-requester request valid                 [NUM_REQ]
//   req_a      packed signed operands, slot i at [i*A_W +: A_W]
//   req_b      packed unsigned operands, slot i at [i*B_W +: B_W]
//   req_ready  one-hot grant-and-accept                     [NUM_REQ]
//   rsp_valid  result valid
//   rsp_ready  consumer ready
//   rsp_id     index of the requester that issued the result [ID_W]
//   rsp_data   low P_W bits of the full product             [P_W]
//   rsp_ovf    full product is outside the signed P_W range
//   busy       operand stage or result stage occupied
// ---------------------------------------------------------------------------
module fast_protocol_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned A_W     = 16,
  parameter int unsigned B_W     = 9,
  parameter int unsigned P_W     = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [P_W-1:0]         rsp_data,
  output logic                   rsp_ovf,
  output logic                   busy
);

  // b is zero-extended by one bit before the signed multiply, so the full
  // product needs A_W + B_W + 1 bits.
  localparam int unsigned PROD_W = A_W + B_W + 1;
  // Bits that must all equal the result sign bit for the result to fit.
  localparam int unsigned HI_W   = PROD_W - P_W + 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ID_W-1:0] rr_q, rr_d;

  logic            op_v_q, op_v_d;
  logic [A_W-1:0]  op_a_q, op_a_d;
  logic [B_W-1:0]  op_b_q, op_b_d;
  logic [ID_W-1:0] op_id_q, op_id_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [P_W-1:0]  rsp_data_q, rsp_data_d;
  logic            rsp_ovf_q, rsp_ovf_d;

  // -------------------------------------------------------------------------
  // Pipeline advance
  // -------------------------------------------------------------------------
  logic adv_rsp;
  logic adv_op;

  // The result register may load when empty or when its content is leaving;
  // the operand register may load when empty or when it moves forward.
  assign adv_rsp = !rsp_valid_q || rsp_ready;
  assign adv_op  = !op_v_q || adv_rsp;

  // -------------------------------------------------------------------------
  // Round-robin arbitration
  // -------------------------------------------------------------------------
  logic               found;
  logic [ID_W-1:0]    win;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               accept;

  // Two passes: first the lowest valid index at or above the pointer, then
  // (wrapping) the lowest valid index below it. Together they search
  // rr, rr+1, ... mod NUM_REQ.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    gnt_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i >= 32'(rr_q))) begin
        found     = 1'b1;
        win       = ID_W'(i);
        gnt_oh[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i < 32'(rr_q))) begin
        found     = 1'b1;
        win       = ID_W'(i);
        gnt_oh[i] = 1'b1;
      end
    end
  end

  // The grant is only exposed while the operand stage can take it, so every
  // asserted ready bit is a completed transfer when paired with its valid.
  assign req_ready = adv_op ? gnt_oh : '0;
  assign accept    = found && adv_op;

  // -------------------------------------------------------------------------
  // Operand mux
  // -------------------------------------------------------------------------
  logic [A_W-1:0] sel_a;
  logic [B_W-1:0] sel_b;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_a = req_a[i*A_W +: A_W];
        sel_b = req_b[i*B_W +: B_W];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Operand stage and pointer next-state
  // -------------------------------------------------------------------------
  always_comb begin
    rr_d    = rr_q;
    op_v_d  = op_v_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    op_id_d = op_id_q;

    if (accept) begin
      op_v_d  = 1'b1;
      op_a_d  = sel_a;
      op_b_d  = sel_b;
      op_id_d = win;
      rr_d    = (32'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
    end else if (adv_op) begin
      // Operand moved on (or stage was already empty) with nothing new.
      op_v_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Multiply and result next-state
  // -------------------------------------------------------------------------
  logic        [PROD_W-1:0] a_ext;
  logic        [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] full;
  logic        [HI_W-1:0]   full_hi;
  logic                     full_ovf;

  assign a_ext    = {{(PROD_W - A_W){op_a_q[A_W-1]}}, op_a_q};
  assign b_ext    = {{(PROD_W - B_W){1'b0}}, op_b_q};
  assign full     = $signed(a_ext) * $signed(b_ext);
  assign full_hi  = full[PROD_W-1:P_W-1];
  // Fits only if the discarded bits and the result sign bit all agree.
  assign full_ovf = !((&full_hi) || !(|full_hi));

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;

    if (adv_rsp) begin
      if (op_v_q) begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = op_id_q;
        rsp_data_d  = full[P_W-1:0];
        rsp_ovf_d   = full_ovf;
      end else begin
        // Payload deliberately left as-is; only the valid drops.
        rsp_valid_d = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_q        <= '0;
      op_v_q      <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      op_v_q      <= op_v_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = op_v_q || rsp_valid_q;

endmodule
